tetris_session_ctrl: RTL and testbench
======================================

Name: tetris_session_ctrl

Overview:
Parametrised menu and session controller for the Tetris build. It handles 1..NUM_PLAYERS player selection, a start countdown, play, game-over and winner arbitration. It sits between the PS/2 key decoders and the per-player game instances: it issues start/stop pulses, holds the active/alive player masks, and reports a state code that the VGA compositor uses to choose the menu page or the game views.

Parameters:
NUM_PLAYERS, 2, number of game instances (1..4); selectable player count is 1..NUM_PLAYERS
COUNT_STEPS, 3, countdown steps shown before play starts (1..15)
STEP_CYCLES, 25000000, clock cycles per countdown step (>=2)
SW, $clog2(NUM_PLAYERS) with minimum 1, width of selection and winner indices (derived localparam)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_key  in  8*NUM_PLAYERS  current scan code per player; player p uses bits [8p+7:8p]; 8'h00 means no key
i_finish  in  NUM_PLAYERS  level from each game instance: that player has topped out
o_state  out  3  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 GAMEOVER
o_sel  out  SW  menu selection; player count = o_sel+1
o_count  out  4  remaining countdown steps; 0 outside COUNTDOWN
o_start  out  1  one-cycle pulse, all games begin
o_stop  out  1  one-cycle pulse, all games freeze
o_pause  out  1  level, games hold
o_active  out  NUM_PLAYERS  players in the current session
o_alive  out  NUM_PLAYERS  active players not yet finished
o_winner  out  SW  winning player index
o_winner_vld  out  1  o_winner is meaningful

Behaviour:
- Reset values: all outputs 0, state IDLE, key history registers 8'h00.
- Key events: each player has a registered previous code. A press event for code K fires in the cycle where i_key==K and prev!=K. Held keys fire once only.
- Only player 0 keys drive the FSM. Codes: up 8'h75, down 8'h72, enter 8'h5A, esc 8'h76, pause 8'h4D.
- All outputs are registered. A response appears on the cycle after the event cycle.
- IDLE:
  - up decrements o_sel, saturating at 0.
  - down increments o_sel, saturating at NUM_PLAYERS-1.
  - enter does the following: o_active <= (1<<(o_sel+1))-1, o_alive <= o_active, o_winner_vld <= 0, o_count <= COUNT_STEPS, step counter cleared, go to COUNTDOWN.
  - When NUM_PLAYERS==1, o_sel is fixed at 0.
- COUNTDOWN:
  - The step counter counts 0..STEP_CYCLES-1. On wrap, o_count decrements.
  - When o_count would reach 0: pulse o_start and go to PLAY. Total duration from entry is COUNT_STEPS*STEP_CYCLES cycles.
  - esc aborts to IDLE with no o_start and no o_stop; o_active is cleared.
  - i_finish and enter are ignored.
- PLAY:
  - Each cycle: o_alive <= o_alive & ~i_finish.
  - Multiplayer (active count >1): when the next alive count <=1, pulse o_stop and go to GAMEOVER.
    - If exactly one player is alive, o_winner = its index and o_winner_vld = 1.
    - If zero are alive (simultaneous finish), o_winner_vld = 0.
  - Single player: any finish pulses o_stop and goes to GAMEOVER with o_winner_vld = 0.
  - esc pulses o_stop and goes to IDLE, clearing o_active and o_alive. esc takes priority over a same-cycle finish.
- PAUSE (feature only):
  - o_pause = 1. i_finish is ignored.
  - pause returns to PLAY.
  - esc pulses o_stop and goes to IDLE.
- GAMEOVER: masks and winner are held. enter or esc returns to IDLE; o_sel is retained.
- o_start and o_stop never assert in the same cycle and never assert for 2 consecutive cycles.
- Asynchronous reset mid-session returns to IDLE immediately, with no stop pulse.

Optional Feature:
SESSION_PAUSE_EN
- Defined: PAUSE state exists; a pause key event in PLAY enters PAUSE and a second event resumes PLAY.
- Undefined: the pause key is ignored, PAUSE is unreachable, and o_pause is tied to 0.

Test Plan:
All scenarios use NUM_PLAYERS=2, COUNT_STEPS=3, STEP_CYCLES=4.
- Menu saturation: hold down for 10 cycles, then up twice as separate presses -> o_sel goes to 1 once (hold gives a single event), then to 0, stays 0.
- Start: enter with o_sel=1 -> o_state=1, o_count 3,2,1 at 4-cycle intervals; o_start pulses exactly 12 cycles after entry; o_active=2'b11, o_state=2.
- Winner: in PLAY, i_finish=2'b10 -> next cycle o_alive=2'b01, o_stop pulse, o_state=4, o_winner=0, o_winner_vld=1.
- Tie plus esc priority: i_finish=2'b11 -> o_winner_vld=0, o_state=4. Separately, esc with i_finish=2'b01 in the same cycle -> o_state=0 and o_stop pulse, no GAMEOVER.
- Countdown abort: esc during o_count=2 -> o_state=0, o_start and o_stop never assert, o_active=0.
- Pause (with SESSION_PAUSE_EN): 8'h4D in PLAY -> o_pause=1, o_state=3, i_finish=2'b01 ignored; second 8'h4D -> o_state=2. Without the macro, o_pause stays 0.

Source files
------------

// File: rtl/tetris_session_ctrl.sv
// tetris_session_ctrl
//   Menu and session controller for the multi-player Tetris build. Player 0's
//   keyboard drives the menu (player count), start countdown, play, optional
//   pause and game-over. The block issues start/stop pulses to the game
//   instances, holds the active/alive masks and arbitrates the winner.
//
// Optional feature macro: SESSION_PAUSE_EN
//   defined   : PAUSE state exists; the pause key toggles PLAY <-> PAUSE
//   undefined : pause key ignored, PAUSE unreachable, o_pause stays 0
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_key            8-bit scan code per player (8'h00 = no key)
//   i_finish         per-player top-out level from the game instances
//   o_state          0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 GAMEOVER
//   o_sel            menu selection, player count = o_sel + 1
//   o_count          remaining countdown steps (0 outside COUNTDOWN)
//   o_start, o_stop  one-cycle pulses to all game instances
//   o_pause          games hold while high
//   o_active         players taking part in the session
//   o_alive          active players that have not finished
//   o_winner(_vld)   winning player index and its qualifier
module tetris_session_ctrl #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned COUNT_STEPS = 3,
    parameter int unsigned STEP_CYCLES = 25000000,
    localparam int unsigned SW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [8*NUM_PLAYERS-1:0] i_key,
    input  logic [NUM_PLAYERS-1:0]   i_finish,
    output logic [2:0]               o_state,
    output logic [SW-1:0]            o_sel,
    output logic [3:0]               o_count,
    output logic                     o_start,
    output logic                     o_stop,
    output logic                     o_pause,
    output logic [NUM_PLAYERS-1:0]   o_active,
    output logic [NUM_PLAYERS-1:0]   o_alive,
    output logic [SW-1:0]            o_winner,
    output logic                     o_winner_vld
);

    localparam int unsigned SCW = $clog2(STEP_CYCLES);
    localparam logic [SCW-1:0] STEP_LAST = SCW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0]  SEL_MAX   = SW'(NUM_PLAYERS - 1);

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
`ifdef SESSION_PAUSE_EN
    localparam logic [7:0] KEY_PAUSE = 8'h4D;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_GAMEOVER  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [SW-1:0]            sel_q, sel_d;
    logic [3:0]               count_q, count_d;
    logic [SCW-1:0]           step_q, step_d;
    logic                     start_q, start_d;
    logic                     stop_q, stop_d;
    logic                     pause_q, pause_d;
    logic [NUM_PLAYERS-1:0]   active_q, active_d;
    logic [NUM_PLAYERS-1:0]   alive_q, alive_d;
    logic [SW-1:0]            winner_q, winner_d;
    logic                     wvld_q, wvld_d;
    logic [8*NUM_PLAYERS-1:0] key_prev_q;

    // Press events: code present now but not in the previous cycle.
    logic [7:0] key0, prev0;
    logic ev_up, ev_down, ev_enter, ev_esc;
    assign key0     = i_key[7:0];
    assign prev0    = key_prev_q[7:0];
    assign ev_up    = (key0 == KEY_UP)    && (prev0 != KEY_UP);
    assign ev_down  = (key0 == KEY_DOWN)  && (prev0 != KEY_DOWN);
    assign ev_enter = (key0 == KEY_ENTER) && (prev0 != KEY_ENTER);
    assign ev_esc   = (key0 == KEY_ESC)   && (prev0 != KEY_ESC);
`ifdef SESSION_PAUSE_EN
    logic ev_pause;
    assign ev_pause = (key0 == KEY_PAUSE) && (prev0 != KEY_PAUSE);
`endif

    logic [NUM_PLAYERS-1:0] entry_mask;
    logic [NUM_PLAYERS-1:0] alive_nx;
    logic [SW-1:0]          alive_idx;
    logic                   multi;
    logic                   one_or_none;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            count_q    <= '0;
            step_q     <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            pause_q    <= 1'b0;
            active_q   <= '0;
            alive_q    <= '0;
            winner_q   <= '0;
            wvld_q     <= 1'b0;
            key_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            count_q    <= count_d;
            step_q     <= step_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            pause_q    <= pause_d;
            active_q   <= active_d;
            alive_q    <= alive_d;
            winner_q   <= winner_d;
            wvld_q     <= wvld_d;
            key_prev_q <= i_key;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        count_d  = count_q;
        step_d   = step_q;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        pause_d  = pause_q;
        active_d = active_q;
        alive_d  = alive_q;
        winner_d = winner_q;
        wvld_d   = wvld_q;

        // Thermometer mask of the selected player count: (1 << (sel+1)) - 1.
        entry_mask = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            entry_mask[p] = (p <= 32'(sel_q));
        end

        alive_nx  = alive_q & ~i_finish;
        alive_idx = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (alive_nx[p]) alive_idx = SW'(p);
        end
        multi       = ($countones(active_q) > 1);
        one_or_none = ($countones(alive_nx) <= 1);

        case (state_q)
            S_IDLE: begin
                if (ev_up) begin
                    if (sel_q != '0) sel_d = sel_q - 1'b1;
                end else if (ev_down) begin
                    if (sel_q < SEL_MAX) sel_d = sel_q + 1'b1;
                end else if (ev_enter) begin
                    active_d = entry_mask;
                    alive_d  = entry_mask;
                    wvld_d   = 1'b0;
                    count_d  = 4'(COUNT_STEPS);
                    step_d   = '0;
                    state_d  = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (ev_esc) begin
                    count_d  = '0;
                    active_d = '0;
                    alive_d  = '0;
                    state_d  = S_IDLE;
                end else if (step_q == STEP_LAST) begin
                    step_d = '0;
                    if (count_q == 4'd1) begin
                        count_d = '0;
                        start_d = 1'b1;
                        state_d = S_PLAY;
                    end else begin
                        count_d = count_q - 4'd1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_PLAY: begin
                if (ev_esc) begin
                    stop_d   = 1'b1;
                    active_d = '0;
                    alive_d  = '0;
                    state_d  = S_IDLE;
                end
`ifdef SESSION_PAUSE_EN
                else if (ev_pause) begin
                    pause_d = 1'b1;
                    state_d = S_PAUSE;
                end
`endif
                else begin
                    alive_d = alive_nx;
                    if (multi) begin
                        if (one_or_none) begin
                            stop_d   = 1'b1;
                            winner_d = alive_idx;
                            wvld_d   = ($countones(alive_nx) == 1);
                            state_d  = S_GAMEOVER;
                        end
                    end else if ((i_finish & alive_q) != '0) begin
                        stop_d  = 1'b1;
                        wvld_d  = 1'b0;
                        state_d = S_GAMEOVER;
                    end
                end
            end
            S_PAUSE: begin
`ifdef SESSION_PAUSE_EN
                if (ev_pause) begin
                    pause_d = 1'b0;
                    state_d = S_PLAY;
                end else if (ev_esc) begin
                    stop_d   = 1'b1;
                    pause_d  = 1'b0;
                    active_d = '0;
                    alive_d  = '0;
                    state_d  = S_IDLE;
                end
`else
                pause_d = 1'b0;
                state_d = S_IDLE;
`endif
            end
            S_GAMEOVER: begin
                if (ev_enter || ev_esc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_state      = state_q;
    assign o_sel        = sel_q;
    assign o_count      = count_q;
    assign o_start      = start_q;
    assign o_stop       = stop_q;
    assign o_pause      = pause_q;
    assign o_active     = active_q;
    assign o_alive      = alive_q;
    assign o_winner     = winner_q;
    assign o_winner_vld = wvld_q;

endmodule

// File: tb/tb_tetris_session_ctrl.sv
module tb_tetris_session_ctrl;

    localparam int NP    = 2;
    localparam int STEPS = 3;
    localparam int STEPC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   key;
    logic [1:0]    fin;
    logic [2:0]    state;
    logic [0:0]    sel;
    logic [3:0]    count;
    logic          start, stop, pause;
    logic [1:0]    active, alive;
    logic [0:0]    winner;
    logic          wvld;

    tetris_session_ctrl #(
        .NUM_PLAYERS(NP),
        .COUNT_STEPS(STEPS),
        .STEP_CYCLES(STEPC)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_key(key),
        .i_finish(fin),
        .o_state(state),
        .o_sel(sel),
        .o_count(count),
        .o_start(start),
        .o_stop(stop),
        .o_pause(pause),
        .o_active(active),
        .o_alive(alive),
        .o_winner(winner),
        .o_winner_vld(wvld)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: session mode uses the published state codes, the
    // countdown is derived from elapsed cycles since entry.
    int          m_state, m_sel, m_count, m_el, m_active, m_alive, m_win;
    bit          m_start, m_stop, m_pause, m_wvld;
    logic [7:0]  m_prev;

    function automatic int ones2(input int x);
        return (x & 1) + ((x >> 1) & 1);
    endfunction

    task automatic model_reset();
        m_state = 0; m_sel = 0; m_count = 0; m_el = 0;
        m_active = 0; m_alive = 0; m_win = 0;
        m_start = 0; m_stop = 0; m_pause = 0; m_wvld = 0;
        m_prev = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] k0, input logic [1:0] f);
        bit e_up, e_dn, e_ent, e_esc, e_pau;
        int na;
        e_up  = (k0 == 8'h75) && (m_prev != 8'h75);
        e_dn  = (k0 == 8'h72) && (m_prev != 8'h72);
        e_ent = (k0 == 8'h5A) && (m_prev != 8'h5A);
        e_esc = (k0 == 8'h76) && (m_prev != 8'h76);
        e_pau = (k0 == 8'h4D) && (m_prev != 8'h4D);
        m_start = 0;
        m_stop  = 0;
        case (m_state)
            0: begin
                if (e_up) begin
                    if (m_sel > 0) m_sel--;
                end else if (e_dn) begin
                    if (m_sel < NP - 1) m_sel++;
                end else if (e_ent) begin
                    m_active = (1 << (m_sel + 1)) - 1;
                    m_alive  = m_active;
                    m_wvld   = 0;
                    m_el     = 0;
                    m_count  = STEPS;
                    m_state  = 1;
                end
            end
            1: begin
                if (e_esc) begin
                    m_state = 0; m_count = 0; m_active = 0; m_alive = 0;
                end else begin
                    m_el++;
                    if (m_el == STEPS * STEPC) begin
                        m_start = 1; m_count = 0; m_state = 2;
                    end else begin
                        m_count = STEPS - m_el / STEPC;
                    end
                end
            end
            2: begin
                if (e_esc) begin
                    m_stop = 1; m_state = 0; m_active = 0; m_alive = 0;
                end
`ifdef SESSION_PAUSE_EN
                else if (e_pau) begin
                    m_state = 3; m_pause = 1;
                end
`endif
                else begin
                    na = m_alive & ~int'(f);
                    if (ones2(m_active) > 1) begin
                        if (ones2(na) <= 1) begin
                            m_stop = 1; m_state = 4;
                            m_wvld = (ones2(na) == 1);
                            m_win  = (na == 2) ? 1 : 0;
                        end
                    end else if ((int'(f) & m_alive) != 0) begin
                        m_stop = 1; m_state = 4; m_wvld = 0;
                    end
                    m_alive = na;
                end
            end
            3: begin
                if (e_pau) begin
                    m_state = 2; m_pause = 0;
                end else if (e_esc) begin
                    m_stop = 1; m_state = 0; m_pause = 0; m_active = 0; m_alive = 0;
                end
            end
            4: begin
                if (e_ent || e_esc) m_state = 0;
            end
            default: m_state = 0;
        endcase
        m_prev = k0;
    endtask

    task automatic check_all();
        chk("state",  32'(state),  m_state);
        chk("sel",    32'(sel),    m_sel);
        chk("count",  32'(count),  m_count);
        chk("start",  32'(start),  32'(m_start));
        chk("stop",   32'(stop),   32'(m_stop));
        chk("pause",  32'(pause),  32'(m_pause));
        chk("active", 32'(active), m_active);
        chk("alive",  32'(alive),  m_alive);
        chk("wvld",   32'(wvld),   32'(m_wvld));
        if (m_wvld) chk("winner", 32'(winner), m_win);
    endtask

    task automatic tick(input logic [7:0] k0, input logic [1:0] f);
        key = {8'($urandom), k0};
        fin = f;
        model_step(k0, f);
        @(negedge clk);
        check_all();
    endtask

    task automatic start_session();
        tick(8'h5A, 2'b00);
        repeat (STEPS * STEPC) tick(8'h00, 2'b00);
    endtask

    initial begin
        logic [7:0] k0;
        int r;
        rst_n = 1'b0;
        key   = '0;
        fin   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Menu: held down gives one step, up saturates at 0.
        repeat (10) tick(8'h72, 2'b00);
        chk("menu_hold", 32'(sel), 1);
        tick(8'h00, 2'b00);
        tick(8'h75, 2'b00);
        tick(8'h00, 2'b00);
        tick(8'h75, 2'b00);
        tick(8'h00, 2'b00);
        chk("menu_sat", 32'(sel), 0);
        tick(8'h72, 2'b00);
        tick(8'h00, 2'b00);

        // Start: o_start exactly STEPS*STEPC cycles after entry.
        tick(8'h5A, 2'b00);
        chk("cd_entry", 32'(count), 3);
        repeat (STEPS * STEPC - 1) tick(8'h00, 2'b00);
        chk("cd_last_state", 32'(state), 1);
        chk("cd_last_start", 32'(start), 0);
        tick(8'h00, 2'b00);
        chk("start_pulse", 32'(start), 1);
        chk("play_state", 32'(state), 2);
        chk("play_active", 32'(active), 3);

        // Winner.
        tick(8'h00, 2'b10);
        chk("win_state", 32'(state), 4);
        chk("win_idx", 32'(winner), 0);
        chk("win_vld", 32'(wvld), 1);
        chk("win_alive", 32'(alive), 1);
        tick(8'h76, 2'b00);
        tick(8'h00, 2'b00);

        // Simultaneous finish.
        start_session();
        tick(8'h00, 2'b11);
        chk("tie_state", 32'(state), 4);
        chk("tie_vld", 32'(wvld), 0);
        tick(8'h5A, 2'b00);
        tick(8'h00, 2'b00);

        // Esc beats a same-cycle finish.
        start_session();
        tick(8'h76, 2'b01);
        chk("escp_state", 32'(state), 0);
        chk("escp_stop", 32'(stop), 1);
        tick(8'h00, 2'b00);
        chk("escp_idle", 32'(state), 0);

        // Countdown abort.
        tick(8'h5A, 2'b00);
        repeat (STEPC + 1) tick(8'h00, 2'b00);
        chk("abort_cnt", 32'(count), 2);
        tick(8'h76, 2'b00);
        chk("abort_state", 32'(state), 0);
        chk("abort_active", 32'(active), 0);
        chk("abort_stop", 32'(stop), 0);
        tick(8'h00, 2'b00);

        // Pause key.
        start_session();
        tick(8'h4D, 2'b00);
`ifdef SESSION_PAUSE_EN
        chk("pause_on", 32'(pause), 1);
        chk("pause_state", 32'(state), 3);
`else
        chk("pause_off", 32'(pause), 0);
        chk("pause_state", 32'(state), 2);
`endif
        tick(8'h00, 2'b01);
        tick(8'h4D, 2'b00);
`ifdef SESSION_PAUSE_EN
        chk("resume_state", 32'(state), 2);
`else
        chk("nopause_go", 32'(state), 4);
`endif
        tick(8'h76, 2'b00);
        tick(8'h00, 2'b00);

        // Asynchronous reset mid-session.
        start_session();
        tick(8'h00, 2'b00);
        #2;
        rst_n = 1'b0;
        key   = '0;
        fin   = '0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Randomized run.
        k0 = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) >= 40) begin
                r = $urandom_range(0, 99);
                if (r < 30)      k0 = 8'h00;
                else if (r < 45) k0 = 8'h75;
                else if (r < 60) k0 = 8'h72;
                else if (r < 80) k0 = 8'h5A;
                else if (r < 84) k0 = 8'h76;
                else if (r < 94) k0 = 8'h4D;
                else             k0 = 8'($urandom_range(0, 255));
            end
            tick(k0, ($urandom_range(0, 99) < 8) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
